wb_stage: RTL and testbench

- Writeback stage of the RV32I pipeline, directly upstream of the register file.
- Takes retiring instructions from the memory stage, holds loads until the data-memory response arrives, and sign/zero-extends load data.
- Selects the result source and drives the register file write port (write enable, destination, write data).
- Provides a valid/ready handshake back to the memory stage and a retired-instruction counter.

---
 rtl/wb_stage_if.sv | 44 ++++
 rtl/wb_stage.sv | 130 +++++++++++++
 tb/tb_wb_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Writeback stage bus bundle: memory-stage handshake, load response, register-file write port.
// Forwarding signals exist only when WB_FWD_EN is defined.
interface wb_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             valid_i;
  logic             ready_o;
  logic             reg_write_i;
  logic [4:0]       rd_i;
  logic [1:0]       result_src_i;
  logic [2:0]       funct3_i;
  logic [XLEN-1:0]  alu_result_i;
  logic [XLEN-1:0]  pc_plus4_i;
  logic             mem_rsp_valid_i;
  logic [XLEN-1:0]  mem_rsp_data_i;
  logic             we_o;
  logic [4:0]       waddr_o;
  logic [XLEN-1:0]  wdata_o;
  logic [CNT_W-1:0] instret_o;
`ifdef WB_FWD_EN
  logic             fwd_valid_o;
  logic [4:0]       fwd_rd_o;
  logic [XLEN-1:0]  fwd_data_o;
`endif

  modport slave (
    input  valid_i, reg_write_i, rd_i, result_src_i, funct3_i,
           alu_result_i, pc_plus4_i, mem_rsp_valid_i, mem_rsp_data_i,
`ifdef WB_FWD_EN
    output fwd_valid_o, fwd_rd_o, fwd_data_o,
`endif
    output ready_o, we_o, waddr_o, wdata_o, instret_o
  );

  modport master (
    output valid_i, reg_write_i, rd_i, result_src_i, funct3_i,
           alu_result_i, pc_plus4_i, mem_rsp_valid_i, mem_rsp_data_i,
`ifdef WB_FWD_EN
    input  fwd_valid_o, fwd_rd_o, fwd_data_o,
`endif
    input  ready_o, we_o, waddr_o, wdata_o, instret_o
  );
endinterface

// File: rtl/wb_stage.sv
// RV32I writeback stage: holds loads until response, extends load data, drives the regfile port.
// Optional same-cycle bypass outputs enabled by defining WB_FWD_EN.
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  wb_stage_if.slave bus
);
  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_WAIT_LOAD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_reg_write;
  logic [4:0]       r_rd;
  logic [1:0]       r_src;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic [XLEN-1:0]  r_val;
  logic [CNT_W-1:0] r_instret;

  logic             w_ready;
  logic             w_we;
  logic             w_done;
  logic             w_accept;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_load;
  logic [XLEN-1:0]  w_wdata;

  assign w_accept = bus.valid_i & w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = (bus.result_src_i == SRC_LOAD) ? S_WAIT_LOAD : S_HOLD;
    end else begin
      case (r_state)
        S_HOLD:      w_state_nxt = S_IDLE;
        S_WAIT_LOAD: if (bus.mem_rsp_valid_i) w_state_nxt = S_IDLE;
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  // A completing load frees the stage in the same cycle, allowing a back-to-back accept.
  always_comb begin
    w_ready = 1'b1;
    w_done  = 1'b0;
    w_we    = 1'b0;
    case (r_state)
      S_HOLD: begin
        w_done = 1'b1;
        w_we   = r_reg_write & (|r_rd);
      end
      S_WAIT_LOAD: begin
        w_ready = bus.mem_rsp_valid_i;
        w_done  = bus.mem_rsp_valid_i;
        w_we    = r_reg_write & (|r_rd) & bus.mem_rsp_valid_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_src       <= SRC_ALU;
      r_funct3    <= '0;
      r_off       <= '0;
      r_val       <= '0;
    end else if (w_accept) begin
      r_reg_write <= bus.reg_write_i;
      r_rd        <= bus.rd_i;
      r_src       <= bus.result_src_i;
      r_funct3    <= bus.funct3_i;
      r_off       <= bus.alu_result_i[1:0];
      r_val       <= (bus.result_src_i == SRC_PC4) ? bus.pc_plus4_i : bus.alu_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_instret <= '0;
    else if (w_done) r_instret <= r_instret + CNT_W'(1);
  end

  // Lane selection from the captured address offset, then sign/zero extension by funct3.
  always_comb begin
    w_byte = 8'(bus.mem_rsp_data_i >> {r_off, 3'b000});
    w_half = 16'(bus.mem_rsp_data_i >> {r_off[1], 4'b0000});
    case (r_funct3)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = bus.mem_rsp_data_i;
    endcase
  end

  always_comb begin
    case (r_src)
      SRC_ALU, SRC_PC4: w_wdata = r_val;
      SRC_LOAD:         w_wdata = w_load;
      default:          w_wdata = '0;
    endcase
  end

  assign bus.ready_o   = w_ready;
  assign bus.we_o      = w_we;
  assign bus.waddr_o   = r_rd;
  assign bus.wdata_o   = w_wdata;
  assign bus.instret_o = r_instret;

`ifdef WB_FWD_EN
  assign bus.fwd_valid_o = w_we;
  assign bus.fwd_rd_o    = r_rd;
  assign bus.fwd_data_o  = w_wdata;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios plus random traffic against a queue-based model.
module tb_wb_stage;
  logic clk;
  logic rst;

  wb_stage_if #(.XLEN(32), .CNT_W(32)) bus ();
  wb_stage_if #(.XLEN(32), .CNT_W(4))  bus4 ();

  wb_stage #(.XLEN(32), .CNT_W(32)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  wb_stage #(.XLEN(32), .CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus4.valid_i         = bus.valid_i;
  assign bus4.reg_write_i     = bus.reg_write_i;
  assign bus4.rd_i            = bus.rd_i;
  assign bus4.result_src_i    = bus.result_src_i;
  assign bus4.funct3_i        = bus.funct3_i;
  assign bus4.alu_result_i    = bus.alu_result_i;
  assign bus4.pc_plus4_i      = bus.pc_plus4_i;
  assign bus4.mem_rsp_valid_i = bus.mem_rsp_valid_i;
  assign bus4.mem_rsp_data_i  = bus.mem_rsp_data_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
  } instr_t;

  instr_t      q[$];
  instr_t      cur;
  int unsigned retired;
  int          checks;
  int          failures;
  logic        exp_ready, exp_done, exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] data);
    int unsigned off, b, h, d;
    off = addr % 4;
    d   = data;
    b   = (d / (32'd1 << (8 * off))) % 256;
    h   = (d / (32'd1 << (16 * (off / 2)))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return data;
    endcase
  endfunction

  // The oldest in-flight instruction retires once its data is available (immediately unless a load).
  task automatic check_all(input string tag);
    instr_t e;
    exp_ready = 1'b1; exp_done = 1'b0; exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    if (q.size() != 0) begin
      e         = q[0];
      exp_done  = (e.src == 2'd1) ? bus.mem_rsp_valid_i : 1'b1;
      exp_ready = exp_done;
      exp_we    = exp_done && e.rw && (e.rd != 0);
      exp_waddr = e.rd;
      case (e.src)
        2'd0:    exp_wdata = e.alu;
        2'd1:    exp_wdata = load_ext(e.f3, e.alu, bus.mem_rsp_data_i);
        2'd2:    exp_wdata = e.pc4;
        default: exp_wdata = 32'd0;
      endcase
    end
    chk({tag, ".ready"},    32'(bus.ready_o), 32'(exp_ready));
    chk({tag, ".we"},       32'(bus.we_o), 32'(exp_we));
    chk({tag, ".instret"},  bus.instret_o, retired);
    chk({tag, ".instret4"}, 32'(bus4.instret_o), retired % 16);
    if (exp_we) begin
      chk({tag, ".waddr"}, 32'(bus.waddr_o), 32'(exp_waddr));
      chk({tag, ".wdata"}, bus.wdata_o, exp_wdata);
    end
`ifdef WB_FWD_EN
    chk({tag, ".fwd_valid"}, 32'(bus.fwd_valid_o), 32'(exp_we));
    if (exp_we) begin
      chk({tag, ".fwd_rd"},   32'(bus.fwd_rd_o), 32'(exp_waddr));
      chk({tag, ".fwd_data"}, bus.fwd_data_o, exp_wdata);
    end
`endif
  endtask

  task automatic cyc(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                     input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                     input logic [31:0] pc4, input logic rsp, input logic [31:0] rdata);
    @(negedge clk);
    bus.valid_i = v;  bus.reg_write_i = rw; bus.rd_i = rd; bus.result_src_i = src;
    bus.funct3_i = f3; bus.alu_result_i = alu; bus.pc_plus4_i = pc4;
    bus.mem_rsp_valid_i = rsp; bus.mem_rsp_data_i = rdata;
    cur = '{rw: rw, rd: rd, src: src, f3: f3, alu: alu, pc4: pc4};
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic rsp, input logic [31:0] rdata);
    cyc(tag, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, rsp, rdata);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) return;
    if (exp_done) begin
      void'(q.pop_front());
      retired++;
    end
    if (bus.valid_i && exp_ready) q.push_back(cur);
  endtask

  initial begin
    checks = 0; failures = 0; retired = 0;
    rst = 1'b0;
    bus.valid_i = 0; bus.reg_write_i = 0; bus.rd_i = 0; bus.result_src_i = 0; bus.funct3_i = 0;
    bus.alu_result_i = 0; bus.pc_plus4_i = 0; bus.mem_rsp_valid_i = 0; bus.mem_rsp_data_i = 0;
    #3;
    check_all("reset");
    chk("reset.waddr", 32'(bus.waddr_o), 32'd0);
    chk("reset.wdata", bus.wdata_o, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Reset while a load is waiting drops it; a later response is ignored.
    cyc("lw_acc", 1, 1, 5'd5, 2'd1, 3'd2, 32'h200, 32'd0, 0, 32'd0); tick();
    idle("lw_wait", 0, 32'd0); tick();
    @(negedge clk);
    bus.valid_i = 0; rst = 1'b0;
    #1;
    q.delete(); retired = 0;
    check_all("rst_mid");
    chk("rst_mid.waddr", 32'(bus.waddr_o), 32'd0);
    tick();
    @(negedge clk); rst = 1'b1;
    idle("stray", 1, 32'hDEAD_BEEF); tick();
    idle("stray_after", 0, 32'd0);
    chk("stray.instret", bus.instret_o, 32'd0);
    tick();

    // ALU op.
    cyc("alu_acc", 1, 1, 5'd3, 2'd0, 3'd0, 32'h1234, 32'd0, 0, 32'd0); tick();
    idle("alu_wr", 0, 32'd0);
    chk("alu_wr.wdata_c", bus.wdata_o, 32'h0000_1234);
    tick();
    idle("alu_cnt", 0, 32'd0);
    chk("alu_cnt.instret_c", bus.instret_o, 32'd1);
    tick();

    // LB sign extension with three waiting cycles.
    cyc("lb_acc", 1, 1, 5'd9, 2'd1, 3'd0, 32'h102, 32'd0, 0, 32'd0); tick();
    for (int i = 0; i < 3; i++) begin
      idle("lb_wait", 0, 32'h0080_0000);
      chk("lb_wait.ready_c", 32'(bus.ready_o), 32'd0);
      tick();
    end
    idle("lb_rsp", 1, 32'h0080_0000);
    chk("lb_rsp.wdata_c", bus.wdata_o, 32'hFFFF_FF80);
    chk("lb_rsp.we_c", 32'(bus.we_o), 32'd1);
    tick();

    // LHU then JAL accepted in the response cycle.
    cyc("lhu_acc", 1, 1, 5'd10, 2'd1, 3'd5, 32'h1002, 32'd0, 0, 32'd0); tick();
    cyc("lhu_rsp", 1, 1, 5'd1, 2'd2, 3'd0, 32'd0, 32'h44, 1, 32'h8001_7FFF);
    chk("lhu_rsp.wdata_c", bus.wdata_o, 32'h0000_8001);
    tick();
    idle("jal_wr", 0, 32'd0);
    chk("jal_wr.wdata_c", bus.wdata_o, 32'h44);
    chk("jal_wr.waddr_c", 32'(bus.waddr_o), 32'd1);
    tick();

    // rd=0 retires without writing; reserved source writes zero.
    cyc("rd0_acc", 1, 1, 5'd0, 2'd0, 3'd0, 32'h55, 32'd0, 0, 32'd0); tick();
    idle("rd0_ret", 0, 32'd0);
    chk("rd0_ret.we_c", 32'(bus.we_o), 32'd0);
    tick();
    cyc("rsv_acc", 1, 1, 5'd7, 2'd3, 3'd0, 32'hFFFF, 32'hABCD, 0, 32'd0); tick();
    idle("rsv_wr", 0, 32'd0);
    chk("rsv_wr.wdata_c", bus.wdata_o, 32'd0);
    tick();

    // Random traffic; enough retirements to wrap the 4-bit counter several times.
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", 1'($urandom_range(0, 9) < 6), 1'($urandom), 5'($urandom_range(0, 31)),
          2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom,
          1'($urandom_range(0, 9) < 4), $urandom);
      tick();
    end
    idle("final", 0, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
